clean_requester: RTL and testbench

CLEAN_REQUESTER -- requirements
Module: clean_requester

---
 rtl/clean_requester.sv | 216 +++++++++++++++++++++
 tb/tb_clean_requester.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clean_requester.sv
// clean_requester: range-hood self-clean request controller.
// Debounced button, 1 s prescaler, fan run-time accounting, REQ/RUN FSM.
module clean_requester #(
  parameter int unsigned CLK_DIV         = 100_000_000,
  parameter int unsigned DEBOUNCE_CYC    = 1_000_000,
  parameter int unsigned REMIND_SEC      = 36000,
  parameter int unsigned ACK_CYC         = 1000,
  parameter int unsigned RUN_TIMEOUT_SEC = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_on,
  input  logic        fan_running,
  input  logic        btn_clean,
  input  logic        cleaning,
  input  logic        done,
  output logic        start_clean,
  output logic        busy,
  output logic        reminder,
  output logic        error,
  output logic [15:0] run_time
);

  localparam int unsigned PW = $clog2(CLK_DIV + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned AW = $clog2(ACK_CYC + 1);
  localparam int unsigned TW = $clog2(RUN_TIMEOUT_SEC + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_CYC - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(RUN_TIMEOUT_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RUN   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_nxt;

  logic          r_sync0;
  logic          r_sync1;
  logic          r_db_level;
  logic [DW-1:0] r_db_cnt;
  logic          w_db_hit;
  logic          w_press;

  logic [PW-1:0] r_pre;
  logic          w_tick;

  logic          r_done_d;
  logic          w_done_rise;

  logic [AW-1:0] r_ack_cnt;
  logic          w_ack_exp;
  logic [TW-1:0] r_to_cnt;
  logic          w_to_exp;

  logic [15:0]   r_run_time;
  logic          w_rt_clr;
  logic          w_rt_inc;

  logic          r_start;
  logic          r_busy;
  logic          r_error;
  logic          w_start_nxt;
  logic          w_busy_nxt;
  logic          w_error_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= btn_clean;
      r_sync1 <= r_sync0;
    end
  end

  // Level starts high so a button held across reset never yields a press.
  assign w_db_hit = (r_sync1 != r_db_level) && (r_db_cnt == DB_LAST);
  assign w_press  = w_db_hit && r_sync1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_db_level <= 1'b1;
      r_db_cnt   <= '0;
    end else if (r_sync1 == r_db_level) begin
      r_db_cnt   <= '0;
    end else if (w_db_hit) begin
      r_db_level <= r_sync1;
      r_db_cnt   <= '0;
    end else begin
      r_db_cnt   <= r_db_cnt + DW'(1);
    end
  end

  assign w_tick = (r_pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  assign w_done_rise = done && !r_done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done_d <= 1'b0;
    end else begin
      r_done_d <= done;
    end
  end

  assign w_ack_exp = (r_ack_cnt == ACK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack_cnt <= '0;
    end else if (r_state == S_REQ) begin
      r_ack_cnt <= r_ack_cnt + AW'(1);
    end else begin
      r_ack_cnt <= '0;
    end
  end

  assign w_to_exp = w_tick && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
    end else if (r_state != S_RUN) begin
      r_to_cnt <= '0;
    end else if (w_tick) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Abort beats everything; done beats timeout; cleaning beats ack timeout.
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_press && is_on) w_nxt = S_REQ;
      end
      S_REQ: begin
        if (!is_on)         w_nxt = S_IDLE;
        else if (cleaning)  w_nxt = S_RUN;
        else if (w_ack_exp) w_nxt = S_FAULT;
      end
      S_RUN: begin
        if (!is_on)           w_nxt = S_IDLE;
        else if (w_done_rise) w_nxt = S_IDLE;
        else if (w_to_exp)    w_nxt = S_FAULT;
      end
      S_FAULT: begin
        if (w_press) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_start_nxt = (w_nxt == S_REQ);
    w_busy_nxt  = (w_nxt == S_REQ) || (w_nxt == S_RUN);
    w_error_nxt = (w_nxt == S_FAULT);
    w_rt_clr    = (r_state == S_RUN) && is_on && w_done_rise;
    w_rt_inc    = (r_state == S_IDLE) && w_tick && fan_running
                  && (r_run_time != 16'hFFFF);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_start <= w_start_nxt;
      r_busy  <= w_busy_nxt;
      r_error <= w_error_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run_time <= '0;
    end else if (w_rt_clr) begin
      r_run_time <= '0;
    end else if (w_rt_inc) begin
      r_run_time <= r_run_time + 16'd1;
    end
  end

  assign start_clean = r_start;
  assign busy        = r_busy;
  assign error       = r_error;
  assign run_time    = r_run_time;
  assign reminder    = 32'(r_run_time) >= REMIND_SEC;

endmodule

// File: tb/tb_clean_requester.sv
// tb_clean_requester: directed + random stimulus for clean_requester,
// compared every cycle with a behavioural model of the hood controller.
`timescale 1ns/1ps
module tb_clean_requester;

  localparam int unsigned CLK_DIV = 10;
  localparam int unsigned DEB     = 4;
  localparam int unsigned REMIND  = 5;
  localparam int unsigned ACK     = 8;
  localparam int unsigned TO      = 30;

  localparam int M_IDLE  = 0;
  localparam int M_REQ   = 1;
  localparam int M_RUN   = 2;
  localparam int M_FAULT = 3;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        rst2  = 1'b0;
  logic        is_on = 1'b0;
  logic        fan   = 1'b0;
  logic        btn   = 1'b0;
  logic        cln   = 1'b0;
  logic        dn    = 1'b0;
  logic        start_clean;
  logic        busy;
  logic        reminder;
  logic        error;
  logic [15:0] run_time;

  logic        s_start;
  logic        s_busy;
  logic        s_rem;
  logic        s_err;
  logic [15:0] s_rt;

  int checks   = 0;
  int failures = 0;
  int ncyc     = 0;

  int m_st, m_b1, m_b2, m_run_val, m_run_len, m_db;
  int m_edges, m_req_n, m_run_ticks, m_done_prev, m_rt;

  clean_requester #(
    .CLK_DIV(CLK_DIV), .DEBOUNCE_CYC(DEB), .REMIND_SEC(REMIND),
    .ACK_CYC(ACK), .RUN_TIMEOUT_SEC(TO)
  ) dut (
    .clk(clk), .rst(rst), .is_on(is_on), .fan_running(fan),
    .btn_clean(btn), .cleaning(cln), .done(dn),
    .start_clean(start_clean), .busy(busy), .reminder(reminder),
    .error(error), .run_time(run_time)
  );

  // One tick per clock so saturation is reachable in a short run.
  clean_requester #(
    .CLK_DIV(1)
  ) u_sat (
    .clk(clk), .rst(rst2), .is_on(1'b0), .fan_running(1'b1),
    .btn_clean(1'b0), .cleaning(1'b0), .done(1'b0),
    .start_clean(s_start), .busy(s_busy), .reminder(s_rem),
    .error(s_err), .run_time(s_rt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_st = M_IDLE; m_b1 = 0; m_b2 = 0;
    m_run_val = 1; m_run_len = 0; m_db = 1;
    m_edges = 0; m_req_n = 0; m_run_ticks = 0;
    m_done_prev = 0; m_rt = 0;
  endtask

  // Model: button seen two clocks late; a level counts once it has
  // been seen for DEB consecutive clocks; press = newly accepted high.
  task automatic m_edge();
    int v, nxt;
    bit tick, press, drise;
    if (!rst) return;
    v = m_b2; m_b2 = m_b1; m_b1 = int'(btn);
    if (v == m_run_val) m_run_len++;
    else begin m_run_val = v; m_run_len = 1; end
    press = 0;
    if (v != m_db && m_run_len == DEB) begin
      press = (v == 1); m_db = v;
    end
    m_edges++;
    tick = (m_edges % CLK_DIV == 0);
    drise = dn && !m_done_prev;
    m_done_prev = int'(dn);
    if (m_st == M_IDLE && tick && fan && m_rt < 65535) m_rt++;
    nxt = m_st;
    case (m_st)
      M_IDLE: if (press && is_on) nxt = M_REQ;
      M_REQ: begin
        m_req_n++;
        if (!is_on) nxt = M_IDLE;
        else if (cln) nxt = M_RUN;
        else if (m_req_n == ACK) nxt = M_FAULT;
      end
      M_RUN: begin
        if (tick) m_run_ticks++;
        if (!is_on) nxt = M_IDLE;
        else if (drise) begin nxt = M_IDLE; m_rt = 0; end
        else if (m_run_ticks == TO) nxt = M_FAULT;
      end
      M_FAULT: if (press) nxt = M_IDLE;
      default: nxt = M_IDLE;
    endcase
    if (nxt == M_REQ && m_st != M_REQ) m_req_n = 0;
    if (nxt == M_RUN && m_st != M_RUN) m_run_ticks = 0;
    m_st = nxt;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".start"}, start_clean, m_st == M_REQ);
    chk({tag, ".busy"}, busy, m_st == M_REQ || m_st == M_RUN);
    chk({tag, ".error"}, error, m_st == M_FAULT);
    chk({tag, ".run_time"}, run_time, m_rt);
    chk({tag, ".reminder"}, reminder, m_rt >= REMIND);
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    m_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc("idle");
  endtask

  task automatic press();
    btn = 1'b1;
    repeat (6) cyc("press");
    btn = 1'b0;
  endtask

  initial begin
    int n;
    int n0;
    int rt_keep;
    bit dn_hit;

    m_reset();
    #12;
    check_all("reset");
    chk("reset.rt0", run_time, 0);
    @(negedge clk);
    rst = 1'b1; rst2 = 1'b1; n0 = ncyc;

    is_on = 1'b1; fan = 1'b1;
    repeat (60) cyc("fan");
    chk("fan60.rt", run_time, 6);
    chk("fan60.rem", reminder, 1);
    fan = 1'b0;
    idle(4);

    press();
    chk("ack.start", start_clean, 1);
    chk("ack.busy", busy, 1);
    repeat (3) cyc("ack_wait");
    cln = 1'b1;
    cyc("ack_run");
    chk("run.start", start_clean, 0);
    chk("run.busy", busy, 1);
    dn = 1'b1;
    cyc("done");
    dn = 1'b0;
    chk("done.busy", busy, 0);
    chk("done.rt", run_time, 0);
    chk("done.rem", reminder, 0);
    cln = 1'b0;
    idle(8);

    press();
    repeat (7) cyc("noack");
    chk("noack.busy", busy, 1);
    cyc("noack_to");
    chk("noack.err", error, 1);
    is_on = 1'b0;
    idle(6);
    press();
    chk("clr.err", error, 0);
    chk("clr.busy", busy, 0);
    is_on = 1'b1;
    idle(8);

    press();
    cln = 1'b1;
    cyc("to_enter");
    for (n = 0; n < 400 && error !== 1'b1; n++) cyc("to");
    chk("to.err", error, 1);
    chk("to.len_ok", (n >= 291 && n <= 300), 1);
    cln = 1'b0;
    idle(4);
    press();
    idle(8);

    press();
    cln = 1'b1;
    cyc("tod_enter");
    dn_hit = 0;
    for (int i = 0; i < 400 && !dn_hit; i++) begin
      if (m_st == M_RUN && m_run_ticks == TO - 1 &&
          ((m_edges + 1) % CLK_DIV == 0)) begin
        dn = 1'b1; dn_hit = 1;
      end
      cyc("tod");
    end
    dn = 1'b0; cln = 1'b0;
    chk("tod.hit", dn_hit, 1);
    chk("tod.busy", busy, 0);
    chk("tod.err", error, 0);
    chk("tod.rt", run_time, 0);
    idle(8);

    btn = 1'b1;
    repeat (2) cyc("glitch");
    btn = 1'b0;
    idle(10);
    chk("glitch.busy", busy, 0);
    fan = 1'b1;
    idle(30);
    fan = 1'b0;
    press();
    cln = 1'b1;
    cyc("abort_enter");
    chk("abort.busy_in", busy, 1);
    rt_keep = m_rt;
    is_on = 1'b0;
    cyc("abort");
    chk("abort.busy", busy, 0);
    chk("abort.start", start_clean, 0);
    chk("abort.rt", run_time, rt_keep);
    is_on = 1'b1; cln = 1'b0;
    idle(8);

    btn = 1'b1;
    repeat (6) cyc("rst_req");
    chk("rst_req.start", start_clean, 1);
    #2 rst = 1'b0;
    m_reset();
    #1;
    chk("rst_req.start0", start_clean, 0);
    chk("rst_req.busy0", busy, 0);
    chk("rst_req.rt0", run_time, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) cyc("rst_hold");
    chk("rst_hold.busy", busy, 0);
    btn = 1'b0;
    idle(8);

    press();
    cln = 1'b1;
    cyc("rst_run");
    chk("rst_run.busy", busy, 1);
    btn = 1'b1;
    #2 rst = 1'b0;
    m_reset();
    #1;
    chk("rst_run.busy0", busy, 0);
    chk("rst_run.start0", start_clean, 0);
    chk("rst_run.err0", error, 0);
    chk("rst_run.rem0", reminder, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) cyc("rst_run_hold");
    chk("rst_run_hold.busy", busy, 0);
    btn = 1'b0; cln = 1'b0;
    idle(8);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) btn = ~btn;
      if (is_on) begin
        if ($urandom_range(79) == 0) is_on = 1'b0;
      end else if ($urandom_range(4) == 0) is_on = 1'b1;
      if ($urandom_range(14) == 0) fan = ~fan;
      cln = ($urandom_range(5) == 0);
      dn  = ($urandom_range(9) == 0);
      cyc("rnd");
    end
    btn = 1'b0; cln = 1'b0; dn = 1'b0;

    while (ncyc - n0 < 65534) @(negedge clk);
    chk("sat.fffe", s_rt, 16'hFFFE);
    @(negedge clk);
    chk("sat.ffff", s_rt, 16'hFFFF);
    repeat (5) @(negedge clk);
    chk("sat.hold", s_rt, 16'hFFFF);
    chk("sat.rem", s_rem, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
